amp_nc_accum: RTL and testbench
===============================

Name: amp_nc_accum

Overview:
- Multi-channel, pipelined complex-amplitude unit for the tracking engine.
- Computes |I+jQ| with the JPL max/min approximation and accumulates amplitudes non-coherently, per channel, over a programmable number of samples.
- Correlator outputs are time-multiplexed onto one input with a channel tag, e.g. E/P/L per correlator.
- Feeds lock detectors and C/N0 estimation.

Parameters:
- DATA_WIDTH, 16: signed I/Q input width; amplitude output width.
- CHANNELS, 8: number of independent accumulation channels.
- CH_WIDTH, 3: channel tag width; must satisfy 2^CH_WIDTH >= CHANNELS.
- ACC_WIDTH, 24: unsigned accumulator width; must be >= DATA_WIDTH.
- CNT_WIDTH, 8: width of the accumulation-length field.

Ports:
- clk  in  1  clock
- rst_b  in  1  asynchronous reset, active-low
- in_valid  in  1  input sample strobe
- in_ch  in  CH_WIDTH  channel tag of input sample
- data_real  in  DATA_WIDTH  signed I
- data_imag  in  DATA_WIDTH  signed Q
- abs_mode  in  1  0 = ones'-complement abs (NOT), 1 = exact two's-complement abs
- acc_len  in  CNT_WIDTH  samples per dump; 0 is treated as 1
- clear  in  1  synchronous clear of all accumulators and counters
- amp_valid  out  1  amplitude result strobe
- amp_ch  out  CH_WIDTH  channel tag of amplitude result
- amp_out  out  DATA_WIDTH  unsigned amplitude
- acc_valid  out  1  accumulation dump strobe
- acc_ch  out  CH_WIDTH  channel tag of dump
- acc_out  out  ACC_WIDTH  unsigned accumulated amplitude

Behaviour:
- Reset: every output is 0; all pipeline valids are 0; all per-channel accumulators and counters are 0.
- Pipeline: one sample per cycle, no backpressure.
  - S1 registers |I| and |Q| (DATA_WIDTH-1 bits each).
  - S2 registers max and min.
  - S3 registers amp_out, amp_valid and amp_ch.
  - Latency in_valid -> amp_valid is exactly 3 cycles.
  - Valid and channel tag travel with the data through every stage.
- abs_mode=0: |x| = x[W-2:0] XOR sign replicated (no +1).
- abs_mode=1: |x| = -x for negative x; the most negative value saturates to 2^(W-1)-1.
- abs_mode is sampled with the data in S1.
- Amplitude rule, evaluated in S2->S3 with unsigned math and no overflow:
  - If max > 3*min: amp = max + (min>>3).
  - Otherwise: amp = max - (max>>3) + (min>>1).
- Accumulation happens at S3, on the registered amplitude, for channel c = amp_ch:
  - new = sat(acc[c] + amp_out) to 2^ACC_WIDTH-1.
  - If cnt[c]+1 >= max(acc_len,1): acc_out = new, acc_ch = c, acc_valid = 1 for one cycle; acc[c] and cnt[c] are set to 0.
  - Otherwise: acc[c] = new and cnt[c] = cnt[c]+1.
- Dump latency: acc_valid occurs 1 cycle after the amp_valid of the final sample, i.e. 4 cycles after in_valid.
- acc_len may change at any time. It is compared live, so a value at or below the current cnt forces a dump on that channel's next sample.
- Channel tag >= CHANNELS: amplitude is still produced; no accumulator is touched; no dump occurs.
- clear: all acc and cnt become 0 on the next edge. A sample accumulating in the same cycle is discarded from the accumulator and produces no dump, but its amp_valid and amp_out still appear. Pipeline stages S1–S3 are not flushed.
- Back-to-back samples on the same channel in consecutive cycles accumulate correctly; the read-modify-write completes within the S3->acc cycle, so no forwarding hazard exists.
- Reset asserted mid-accumulation: all state returns to reset values and no dump is produced.

Decomposition:
- Package amp_pkg holds:
  - ABS_ONES = 1'b0 and ABS_EXACT = 1'b1.
  - Function jpl_amp(max, min) returning DATA_WIDTH bits.
  - Function sat_add for the accumulator.
- Natural sub-module amp_jpl_pipe: the 3-stage abs/max-min/amplitude pipeline, carrying valid and tag.
- The top level adds the per-channel accumulator/counter register arrays and the dump logic.

Test Plan:
- W=16, abs_mode=1, (I,Q)=(3,4) ch0 -> 3 cycles later amp_valid=1, amp_ch=0, amp_out=5 (4 > 9 false, so 4-0+1).
- (I,Q)=(-1000,100): abs_mode=1 -> amp_out=1012; abs_mode=0 -> amp_out=1011 (|I|=999).
- acc_len=4, ch2 fed (3,4) in four consecutive cycles -> single acc_valid with acc_ch=2, acc_out=20, 4 cycles after the fourth input; ch2 state is 0 afterwards.
- ACC_WIDTH=17, acc_len=4, abs_mode=1, (-32768,-32768) ×4:
  - each amp_out=45055;
  - acc_out saturates at 131071.
- Interleaved ch0/ch1 with acc_len=2, plus clear pulsed coincident with ch1's first S3 sample:
  - ch1 dumps only after two later samples;
  - ch0 is unaffected if its samples fall outside the clear cycle;
  - amp_valid is uninterrupted.
- acc_len=0: every sample dumps with acc_out=amp_out. in_ch=7 with CHANNELS=6: amplitude is output and no acc_valid occurs. rst_b pulled low mid-accumulation: all outputs drop to 0 and no dump follows.

Source files
------------

// File: rtl/amp_pkg.sv
// amp_pkg: shared constants and arithmetic helpers for the amplitude /
// non-coherent accumulation slice.
//   ABS_ONES / ABS_EXACT : encodings of the abs_mode input
//   jpl_amp()            : JPL max/min magnitude approximation
//   sat_add()            : unsigned add clamped to a caller-supplied limit
// The helpers use a fixed 32-bit working width so that any instance
// parameterisation can call them. Callers narrow the result with a size cast.
package amp_pkg;

    localparam logic ABS_ONES  = 1'b0;
    localparam logic ABS_EXACT = 1'b1;

    // max + min/8 when max dominates, else 7/8*max + min/2. The inputs are
    // at most W-1 bits wide, so the result always fits in W bits.
    function automatic logic [31:0] jpl_amp(input logic [31:0] max_v,
                                            input logic [31:0] min_v);
        logic [33:0] three_min;
        logic [31:0] res;
        three_min = {2'b00, min_v} + {1'b0, min_v, 1'b0};
        if ({2'b00, max_v} > three_min) begin
            res = max_v + (min_v >> 3'd3);
        end else begin
            res = max_v - (max_v >> 3'd3) + (min_v >> 3'd1);
        end
        return res;
    endfunction

    // Unsigned a + b, clamped to lim. The sum is formed one bit wider so a
    // wrap can never hide an overflow.
    function automatic logic [31:0] sat_add(input logic [31:0] a,
                                            input logic [31:0] b,
                                            input logic [31:0] lim);
        logic [32:0] sum;
        logic [31:0] res;
        sum = {1'b0, a} + {1'b0, b};
        if (sum > {1'b0, lim}) begin
            res = lim;
        end else begin
            res = sum[31:0];
        end
        return res;
    endfunction

endpackage

// File: rtl/amp_jpl_pipe.sv
// amp_jpl_pipe: three-stage magnitude pipeline.
//   S1: |I|, |Q| (abs_mode sampled with the data)
//   S2: max, min
//   S3: JPL amplitude
// The valid strobe and channel tag travel alongside the data.
// Ports: clk, rst_b (async, active-low), in_valid/in_ch/data_real/data_imag/
//        abs_mode in; amp_valid/amp_ch/amp_out out (registered).
module amp_jpl_pipe #(
    parameter int DATA_WIDTH = 16,
    parameter int CH_WIDTH   = 3
) (
    input  logic                  clk,
    input  logic                  rst_b,
    input  logic                  in_valid,
    input  logic [CH_WIDTH-1:0]   in_ch,
    input  logic [DATA_WIDTH-1:0] data_real,
    input  logic [DATA_WIDTH-1:0] data_imag,
    input  logic                  abs_mode,
    output logic                  amp_valid,
    output logic [CH_WIDTH-1:0]   amp_ch,
    output logic [DATA_WIDTH-1:0] amp_out
);
    import amp_pkg::*;

    localparam int MW = DATA_WIDTH - 1;

    // Ones'-complement mode inverts the magnitude bits without adding one.
    // Exact mode negates, and the most negative input saturates to all ones.
    function automatic logic [MW-1:0] abs_val(input logic [DATA_WIDTH-1:0] x,
                                              input logic              mode);
        logic [MW-1:0] res;
        if (mode == ABS_ONES) begin
            res = x[MW-1:0] ^ {MW{x[DATA_WIDTH-1]}};
        end else if (!x[DATA_WIDTH-1]) begin
            res = x[MW-1:0];
        end else if (x[MW-1:0] == '0) begin
            res = '1;
        end else begin
            res = ~x[MW-1:0] + {{(MW-1){1'b0}}, 1'b1};
        end
        return res;
    endfunction

    logic                  s1_valid_d, s1_valid_q;
    logic [CH_WIDTH-1:0]   s1_ch_d,    s1_ch_q;
    logic [MW-1:0]         abs_i_d,    abs_i_q;
    logic [MW-1:0]         abs_q_d,    abs_q_q;
    logic                  s2_valid_d, s2_valid_q;
    logic [CH_WIDTH-1:0]   s2_ch_d,    s2_ch_q;
    logic [MW-1:0]         max_d,      max_q;
    logic [MW-1:0]         min_d,      min_q;
    logic                  amp_valid_d, amp_valid_q;
    logic [CH_WIDTH-1:0]   amp_ch_d,    amp_ch_q;
    logic [DATA_WIDTH-1:0] amp_out_d,   amp_out_q;

    // Next-state for all three pipeline stages.
    always_comb begin
        s1_valid_d = in_valid;
        s1_ch_d    = in_ch;
        abs_i_d    = abs_val(data_real, abs_mode);
        abs_q_d    = abs_val(data_imag, abs_mode);

        s2_valid_d = s1_valid_q;
        s2_ch_d    = s1_ch_q;
        if (abs_i_q >= abs_q_q) begin
            max_d = abs_i_q;
            min_d = abs_q_q;
        end else begin
            max_d = abs_q_q;
            min_d = abs_i_q;
        end

        amp_valid_d = s2_valid_q;
        amp_ch_d    = s2_ch_q;
        amp_out_d   = DATA_WIDTH'(jpl_amp(32'(max_q), 32'(min_q)));
    end

    // Pipeline registers.
    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            s1_valid_q  <= 1'b0;
            s1_ch_q     <= '0;
            abs_i_q     <= '0;
            abs_q_q     <= '0;
            s2_valid_q  <= 1'b0;
            s2_ch_q     <= '0;
            max_q       <= '0;
            min_q       <= '0;
            amp_valid_q <= 1'b0;
            amp_ch_q    <= '0;
            amp_out_q   <= '0;
        end else begin
            s1_valid_q  <= s1_valid_d;
            s1_ch_q     <= s1_ch_d;
            abs_i_q     <= abs_i_d;
            abs_q_q     <= abs_q_d;
            s2_valid_q  <= s2_valid_d;
            s2_ch_q     <= s2_ch_d;
            max_q       <= max_d;
            min_q       <= min_d;
            amp_valid_q <= amp_valid_d;
            amp_ch_q    <= amp_ch_d;
            amp_out_q   <= amp_out_d;
        end
    end

    assign amp_valid = amp_valid_q;
    assign amp_ch    = amp_ch_q;
    assign amp_out   = amp_out_q;

endmodule

// File: rtl/amp_nc_accum.sv
// amp_nc_accum: per-channel non-coherent amplitude accumulator.
// The amplitude pipeline (amp_jpl_pipe) feeds a bank of saturating
// accumulators and sample counters. A channel dumps when its count reaches
// acc_len (0 behaves as 1). Tags >= CHANNELS produce an amplitude but do not
// touch any accumulator.
// Ports: clk, rst_b (async, active-low), in_valid/in_ch/data_real/data_imag,
//        abs_mode, acc_len, clear in; amp_valid/amp_ch/amp_out and
//        acc_valid/acc_ch/acc_out out (all registered).
module amp_nc_accum #(
    parameter int DATA_WIDTH = 16,
    parameter int CHANNELS   = 8,
    parameter int CH_WIDTH   = 3,
    parameter int ACC_WIDTH  = 24,
    parameter int CNT_WIDTH  = 8
) (
    input  logic                  clk,
    input  logic                  rst_b,
    input  logic                  in_valid,
    input  logic [CH_WIDTH-1:0]   in_ch,
    input  logic [DATA_WIDTH-1:0] data_real,
    input  logic [DATA_WIDTH-1:0] data_imag,
    input  logic                  abs_mode,
    input  logic [CNT_WIDTH-1:0]  acc_len,
    input  logic                  clear,
    output logic                  amp_valid,
    output logic [CH_WIDTH-1:0]   amp_ch,
    output logic [DATA_WIDTH-1:0] amp_out,
    output logic                  acc_valid,
    output logic [CH_WIDTH-1:0]   acc_ch,
    output logic [ACC_WIDTH-1:0]  acc_out
);
    import amp_pkg::*;

    localparam logic [ACC_WIDTH-1:0] ACC_MAX = '1;

    amp_jpl_pipe #(
        .DATA_WIDTH (DATA_WIDTH),
        .CH_WIDTH   (CH_WIDTH)
    ) u_pipe (
        .clk       (clk),
        .rst_b     (rst_b),
        .in_valid  (in_valid),
        .in_ch     (in_ch),
        .data_real (data_real),
        .data_imag (data_imag),
        .abs_mode  (abs_mode),
        .amp_valid (amp_valid),
        .amp_ch    (amp_ch),
        .amp_out   (amp_out)
    );

    logic [ACC_WIDTH-1:0] acc_d [CHANNELS];
    logic [ACC_WIDTH-1:0] acc_q [CHANNELS];
    logic [CNT_WIDTH-1:0] cnt_d [CHANNELS];
    logic [CNT_WIDTH-1:0] cnt_q [CHANNELS];
    logic                 acc_valid_d, acc_valid_q;
    logic [CH_WIDTH-1:0]  acc_ch_d,    acc_ch_q;
    logic [ACC_WIDTH-1:0] acc_out_d,   acc_out_q;

    logic [CHANNELS-1:0]  hit_s;
    logic [ACC_WIDTH-1:0] sel_acc_s;
    logic [CNT_WIDTH-1:0] sel_cnt_s;
    logic [ACC_WIDTH-1:0] acc_new_s;
    logic [CNT_WIDTH:0]   cnt_inc_s;
    logic [CNT_WIDTH-1:0] len_eff_s;
    logic                 dump_s;

    // Read-modify-write of the channel addressed by the S3 sample, plus dump.
    // The whole update completes in one cycle, so back-to-back samples on the
    // same channel always see the freshly written state.
    always_comb begin
        acc_d       = acc_q;
        cnt_d       = cnt_q;
        acc_valid_d = 1'b0;
        acc_ch_d    = acc_ch_q;
        acc_out_d   = acc_out_q;

        // One-hot channel select; out-of-range tags select nothing.
        sel_acc_s = '0;
        sel_cnt_s = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            hit_s[i]  = (amp_ch == CH_WIDTH'(i));
            sel_acc_s = sel_acc_s | (acc_q[i] & {ACC_WIDTH{hit_s[i]}});
            sel_cnt_s = sel_cnt_s | (cnt_q[i] & {CNT_WIDTH{hit_s[i]}});
        end

        len_eff_s = (acc_len == '0) ? {{(CNT_WIDTH-1){1'b0}}, 1'b1} : acc_len;
        acc_new_s = ACC_WIDTH'(sat_add(32'(sel_acc_s), 32'(amp_out), 32'(ACC_MAX)));
        cnt_inc_s = {1'b0, sel_cnt_s} + {{CNT_WIDTH{1'b0}}, 1'b1};
        dump_s    = (cnt_inc_s >= {1'b0, len_eff_s});

        if (clear) begin
            // Clear wins over any sample in S3: that sample is dropped.
            for (int i = 0; i < CHANNELS; i++) begin
                acc_d[i] = '0;
                cnt_d[i] = '0;
            end
        end else if (amp_valid && (|hit_s)) begin
            for (int i = 0; i < CHANNELS; i++) begin
                acc_d[i] = !hit_s[i] ? acc_q[i] : (dump_s ? '0 : acc_new_s);
                cnt_d[i] = !hit_s[i] ? cnt_q[i] : (dump_s ? '0 : cnt_inc_s[CNT_WIDTH-1:0]);
            end
            acc_valid_d = dump_s;
            acc_ch_d    = dump_s ? amp_ch : acc_ch_q;
            acc_out_d   = dump_s ? acc_new_s : acc_out_q;
        end else begin
            acc_valid_d = 1'b0;
        end
    end

    // Accumulator bank and dump output registers.
    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            for (int i = 0; i < CHANNELS; i++) begin
                acc_q[i] <= '0;
                cnt_q[i] <= '0;
            end
            acc_valid_q <= 1'b0;
            acc_ch_q    <= '0;
            acc_out_q   <= '0;
        end else begin
            acc_q       <= acc_d;
            cnt_q       <= cnt_d;
            acc_valid_q <= acc_valid_d;
            acc_ch_q    <= acc_ch_d;
            acc_out_q   <= acc_out_d;
        end
    end

    assign acc_valid = acc_valid_q;
    assign acc_ch    = acc_ch_q;
    assign acc_out   = acc_out_q;

endmodule

// File: tb/tb_amp_nc_accum.sv
// Directed bench for amp_nc_accum. Three instances share one stimulus:
//   dut_a: default parameters
//   dut_b: ACC_WIDTH=17 (saturation)
//   dut_c: CHANNELS=6 (out-of-range tag)
// Inputs change on the falling edge, and outputs are sampled on the falling edge.
module tb_amp_nc_accum;

    logic        clk = 1'b0;
    logic        rst_b;
    logic        in_valid;
    logic [2:0]  in_ch;
    logic [15:0] data_real;
    logic [15:0] data_imag;
    logic        abs_mode;
    logic [7:0]  acc_len;
    logic        clear;

    logic        a_amp_valid, b_amp_valid, c_amp_valid;
    logic [2:0]  a_amp_ch,    b_amp_ch,    c_amp_ch;
    logic [15:0] a_amp_out,   b_amp_out,   c_amp_out;
    logic        a_acc_valid, b_acc_valid, c_acc_valid;
    logic [2:0]  a_acc_ch,    b_acc_ch,    c_acc_ch;
    logic [23:0] a_acc_out,   c_acc_out;
    logic [16:0] b_acc_out;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    amp_nc_accum dut_a (
        .clk(clk), .rst_b(rst_b), .in_valid(in_valid), .in_ch(in_ch),
        .data_real(data_real), .data_imag(data_imag), .abs_mode(abs_mode),
        .acc_len(acc_len), .clear(clear),
        .amp_valid(a_amp_valid), .amp_ch(a_amp_ch), .amp_out(a_amp_out),
        .acc_valid(a_acc_valid), .acc_ch(a_acc_ch), .acc_out(a_acc_out)
    );

    amp_nc_accum #(.ACC_WIDTH(17)) dut_b (
        .clk(clk), .rst_b(rst_b), .in_valid(in_valid), .in_ch(in_ch),
        .data_real(data_real), .data_imag(data_imag), .abs_mode(abs_mode),
        .acc_len(acc_len), .clear(clear),
        .amp_valid(b_amp_valid), .amp_ch(b_amp_ch), .amp_out(b_amp_out),
        .acc_valid(b_acc_valid), .acc_ch(b_acc_ch), .acc_out(b_acc_out)
    );

    amp_nc_accum #(.CHANNELS(6)) dut_c (
        .clk(clk), .rst_b(rst_b), .in_valid(in_valid), .in_ch(in_ch),
        .data_real(data_real), .data_imag(data_imag), .abs_mode(abs_mode),
        .acc_len(acc_len), .clear(clear),
        .amp_valid(c_amp_valid), .amp_ch(c_amp_ch), .amp_out(c_amp_out),
        .acc_valid(c_acc_valid), .acc_ch(c_acc_ch), .acc_out(c_acc_out)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Present one sample for one cycle; returns on the next falling edge.
    task automatic send(input logic [2:0] ch, input logic [15:0] i, input logic [15:0] q);
        in_valid  = 1'b1;
        in_ch     = ch;
        data_real = i;
        data_imag = q;
        @(negedge clk);
    endtask

    task automatic idle();
        in_valid = 1'b0;
    endtask

    task automatic do_clear();
        clear = 1'b1;
        @(negedge clk);
        clear = 1'b0;
    endtask

    initial begin
        rst_b = 1'b0; in_valid = 1'b0; in_ch = 3'd0;
        data_real = 16'd0; data_imag = 16'd0;
        abs_mode = 1'b1; acc_len = 8'd4; clear = 1'b0;
        tick(2);
        chk("rst_amp_valid", 32'(a_amp_valid), 32'd0);
        chk("rst_amp_out",   32'(a_amp_out),   32'd0);
        chk("rst_acc_valid", 32'(a_acc_valid), 32'd0);
        chk("rst_acc_out",   32'(a_acc_out),   32'd0);
        rst_b = 1'b1;
        tick(1);

        // (3,4) on ch0: amplitude 5, exactly three cycles later.
        send(3'd0, 16'd3, 16'd4); idle();
        tick(1);
        chk("lat_not_early", 32'(a_amp_valid), 32'd0);
        tick(1);
        chk("amp34_valid", 32'(a_amp_valid), 32'd1);
        chk("amp34_ch",    32'(a_amp_ch),    32'd0);
        chk("amp34_out",   32'(a_amp_out),   32'd5);
        tick(2); do_clear();

        // (-1000,100): exact abs gives 1012, and ones'-complement abs gives 1011.
        abs_mode = 1'b1; send(3'd0, 16'hFC18, 16'd100);
        abs_mode = 1'b0; send(3'd0, 16'hFC18, 16'd100);
        idle(); abs_mode = 1'b1;
        tick(1);
        chk("abs_exact", 32'(a_amp_out), 32'd1012);
        tick(1);
        chk("abs_ones",  32'(a_amp_out), 32'd1011);
        tick(2); do_clear();

        // acc_len=4, four samples on ch2: one dump of 20.
        acc_len = 8'd4;
        repeat (4) send(3'd2, 16'd3, 16'd4);
        idle();
        tick(2);
        chk("dump_not_early", 32'(a_acc_valid), 32'd0);
        tick(1);
        chk("dump4_valid", 32'(a_acc_valid), 32'd1);
        chk("dump4_ch",    32'(a_acc_ch),    32'd2);
        chk("dump4_out",   32'(a_acc_out),   32'd20);
        tick(1);
        chk("dump4_one_cycle", 32'(a_acc_valid), 32'd0);
        // The ch2 state must be empty again: one sample with len 1 dumps 5.
        acc_len = 8'd1;
        send(3'd2, 16'd3, 16'd4); idle();
        tick(3);
        chk("ch2_zeroed_valid", 32'(a_acc_valid), 32'd1);
        chk("ch2_zeroed_out",   32'(a_acc_out),   32'd5);
        tick(2); do_clear();

        // Most-negative inputs: amplitude 45055. Four of them saturate the 17-bit accumulator.
        acc_len = 8'd4;
        repeat (4) send(3'd0, 16'h8000, 16'h8000);
        idle();
        chk("minneg_amp_a", 32'(a_amp_out), 32'd45055);
        chk("minneg_amp_b", 32'(b_amp_out), 32'd45055);
        tick(3);
        chk("sat_valid_b", 32'(b_acc_valid), 32'd1);
        chk("sat_out_b",   32'(b_acc_out),   32'd131071);
        chk("nosat_out_a", 32'(a_acc_out),   32'd180220);
        tick(2); do_clear();

        // Interleaved ch1/ch0 with acc_len=2; clear coincides with ch1's first S3 sample.
        acc_len = 8'd2;
        send(3'd1, 16'd6, 16'd8);
        send(3'd0, 16'd3, 16'd4);
        send(3'd0, 16'd3, 16'd4);
        chk("clr_amp_valid", 32'(a_amp_valid), 32'd1);
        chk("clr_amp_ch",    32'(a_amp_ch),    32'd1);
        chk("clr_amp_out",   32'(a_amp_out),   32'd10);
        clear = 1'b1;
        send(3'd1, 16'd6, 16'd8);
        clear = 1'b0;
        send(3'd1, 16'd6, 16'd8);
        idle();
        chk("clr_no_dump",   32'(a_acc_valid), 32'd0);
        chk("clr_amp_cont1", 32'(a_amp_valid), 32'd1);
        tick(1);
        chk("clr_ch0_valid", 32'(a_acc_valid), 32'd1);
        chk("clr_ch0_ch",    32'(a_acc_ch),    32'd0);
        chk("clr_ch0_out",   32'(a_acc_out),   32'd10);
        chk("clr_amp_cont2", 32'(a_amp_valid), 32'd1);
        tick(1);
        chk("clr_ch1_wait",  32'(a_acc_valid), 32'd0);
        chk("clr_amp_cont3", 32'(a_amp_valid), 32'd1);
        tick(1);
        chk("clr_ch1_valid", 32'(a_acc_valid), 32'd1);
        chk("clr_ch1_ch",    32'(a_acc_ch),    32'd1);
        chk("clr_ch1_out",   32'(a_acc_out),   32'd20);
        tick(2); do_clear();

        // acc_len=0 behaves as 1: every sample dumps its own amplitude.
        acc_len = 8'd0;
        send(3'd3, 16'd3, 16'd4);
        send(3'd3, 16'hFC18, 16'd100);
        idle();
        tick(2);
        chk("len0_first_valid", 32'(a_acc_valid), 32'd1);
        chk("len0_first_out",   32'(a_acc_out),   32'd5);
        chk("len0_first_ch",    32'(a_acc_ch),    32'd3);
        tick(1);
        chk("len0_second_valid", 32'(a_acc_valid), 32'd1);
        chk("len0_second_out",   32'(a_acc_out),   32'd1012);

        // Tag 7 with CHANNELS=6 produces an amplitude but no dump.
        tick(2);
        send(3'd7, 16'd3, 16'd4); idle();
        tick(2);
        chk("oor_amp_valid", 32'(c_amp_valid), 32'd1);
        chk("oor_amp_ch",    32'(c_amp_ch),    32'd7);
        chk("oor_amp_out",   32'(c_amp_out),   32'd5);
        tick(1);
        chk("oor_no_dump",   32'(c_acc_valid), 32'd0);
        chk("inrange_dump",  32'(a_acc_valid), 32'd1);
        chk("inrange_ch",    32'(a_acc_ch),    32'd7);
        tick(2); do_clear();

        // Reset asserted mid-accumulation: outputs drop at once and no dump follows.
        acc_len = 8'd2;
        send(3'd0, 16'd3, 16'd4);
        send(3'd0, 16'd3, 16'd4);
        idle();
        tick(1);
        rst_b = 1'b0;
        #1;
        chk("mid_rst_amp_valid", 32'(a_amp_valid), 32'd0);
        chk("mid_rst_amp_out",   32'(a_amp_out),   32'd0);
        chk("mid_rst_acc_valid", 32'(a_acc_valid), 32'd0);
        chk("mid_rst_acc_out",   32'(a_acc_out),   32'd0);
        chk("mid_rst_acc_ch",    32'(a_acc_ch),    32'd0);
        @(negedge clk);
        rst_b = 1'b1;
        tick(1);
        chk("post_rst_no_dump1", 32'(a_acc_valid), 32'd0);
        tick(1);
        chk("post_rst_no_dump2", 32'(a_acc_valid), 32'd0);
        acc_len = 8'd1;
        send(3'd0, 16'd3, 16'd4); idle();
        tick(3);
        chk("post_rst_fresh_valid", 32'(a_acc_valid), 32'd1);
        chk("post_rst_fresh_out",   32'(a_acc_out),   32'd5);
        tick(2);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
